// File: rtl/vga_sync_pipe.sv
// Parametrised VGA timing generator with an output alignment pipeline.
// Stage 0 (req/addresses/pulses) is registered from the h/v counters. Sync and active flags
// then pass through PIPE_DEPTH stages and a final output register that also samples rgb_in,
// so sync, de and colour leave cycle-aligned.
module vga_sync_pipe #(
    parameter int unsigned H_SYNC     = 120,
    parameter int unsigned H_BACK     = 64,
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_FRONT    = 56,
    parameter int unsigned V_SYNC     = 6,
    parameter int unsigned V_BACK     = 23,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned V_FRONT    = 37,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned RGB_W      = 1,
    parameter int unsigned AW         = 11
) (
    input  logic               clk,
    input  logic               rst,
    output logic               req,
    output logic [AW-1:0]      column_addr,
    output logic [AW-1:0]      row_addr,
    output logic               frame_start,
    output logic               line_start,
    input  logic [3*RGB_W-1:0] rgb_in,
    output logic               hsync_sig,
    output logic               vsync_sig,
    output logic               de,
    output logic [RGB_W-1:0]   red_sig,
    output logic [RGB_W-1:0]   green_sig,
    output logic [RGB_W-1:0]   blue_sig
);

    localparam int unsigned H_TOTAL   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_ACT_BEG = H_SYNC + H_BACK;
    localparam int unsigned H_ACT_END = H_ACT_BEG + H_ACTIVE;
    localparam int unsigned V_ACT_BEG = V_SYNC + V_BACK;
    localparam int unsigned V_ACT_END = V_ACT_BEG + V_ACTIVE;
    localparam longint unsigned CNT_SPAN = 64'd1 << AW;

    localparam logic [AW-1:0] H_LAST      = AW'(H_TOTAL - 1);
    localparam logic [AW-1:0] V_LAST      = AW'(V_TOTAL - 1);
    localparam logic [AW-1:0] H_SYNC_C    = AW'(H_SYNC);
    localparam logic [AW-1:0] V_SYNC_C    = AW'(V_SYNC);
    localparam logic [AW-1:0] H_ACT_BEG_C = AW'(H_ACT_BEG);
    localparam logic [AW-1:0] H_ACT_END_C = AW'(H_ACT_END);
    localparam logic [AW-1:0] V_ACT_BEG_C = AW'(V_ACT_BEG);
    localparam logic [AW-1:0] V_ACT_END_C = AW'(V_ACT_END);

    if (64'(H_TOTAL) >= CNT_SPAN) begin : g_h_total_too_big
        $error("vga_sync_pipe: H_TOTAL must be below 2**AW");
    end
    if (64'(V_TOTAL) >= CNT_SPAN) begin : g_v_total_too_big
        $error("vga_sync_pipe: V_TOTAL must be below 2**AW");
    end
    if (PIPE_DEPTH > 15) begin : g_pipe_depth_too_big
        $error("vga_sync_pipe: PIPE_DEPTH must be in 0..15");
    end

    logic [AW-1:0] h_cnt_q, h_cnt_d;
    logic [AW-1:0] v_cnt_q, v_cnt_d;
    logic          h_wrap;

    logic          h_act, v_act, act_d, hs_d, vs_d, fs_d, ls_d;
    logic [AW-1:0] col_d, row_d;
    logic [AW-1:0] col_q, row_q;
    logic          fs_q, ls_q;

    // Index 0 is the undelayed stage; index PIPE_DEPTH feeds the output register.
    logic [PIPE_DEPTH:0] hs_sr, vs_sr, de_sr;

    logic               hsync_q, vsync_q, de_q;
    logic [3*RGB_W-1:0] rgb_q;

    // Next-state of the free-running h/v counters.
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + AW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + AW'(1);
        end
    end

    // Counter state; reset restarts the frame with no partial-line completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage-0 decode of region, sync levels, addresses and start pulses.
    always_comb begin
        h_act = (h_cnt_q >= H_ACT_BEG_C) && (h_cnt_q < H_ACT_END_C);
        v_act = (v_cnt_q >= V_ACT_BEG_C) && (v_cnt_q < V_ACT_END_C);
        act_d = h_act && v_act;
        hs_d  = (h_cnt_q < H_SYNC_C) ? HS_POL : ~HS_POL;
        vs_d  = (v_cnt_q < V_SYNC_C) ? VS_POL : ~VS_POL;
        col_d = act_d ? (h_cnt_q - H_ACT_BEG_C) : '0;
        row_d = act_d ? (v_cnt_q - V_ACT_BEG_C) : '0;
        fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
        ls_d  = (h_cnt_q == '0);
    end

    // Stage-0 address and pulse registers, changing on the same edge as req.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            fs_q  <= fs_d;
            ls_q  <= ls_d;
        end
    end

    if (PIPE_DEPTH > 0) begin : g_pipe
        // Stage 0 plus PIPE_DEPTH delay stages, flushed to inactive levels on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                hs_sr <= {(PIPE_DEPTH + 1){~HS_POL}};
                vs_sr <= {(PIPE_DEPTH + 1){~VS_POL}};
                de_sr <= '0;
            end else begin
                hs_sr <= {hs_sr[PIPE_DEPTH-1:0], hs_d};
                vs_sr <= {vs_sr[PIPE_DEPTH-1:0], vs_d};
                de_sr <= {de_sr[PIPE_DEPTH-1:0], act_d};
            end
        end
    end else begin : g_no_pipe
        // Zero-depth case: only the stage-0 register exists.
        always_ff @(posedge clk) begin
            if (rst) begin
                hs_sr <= ~HS_POL;
                vs_sr <= ~VS_POL;
                de_sr <= 1'b0;
            end else begin
                hs_sr <= hs_d;
                vs_sr <= vs_d;
                de_sr <= act_d;
            end
        end
    end

    // Output register: aligned sync/de with rgb_in sampled alongside and blanked outside de.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hs_sr[PIPE_DEPTH];
            vsync_q <= vs_sr[PIPE_DEPTH];
            de_q    <= de_sr[PIPE_DEPTH];
            rgb_q   <= de_sr[PIPE_DEPTH] ? rgb_in : '0;
        end
    end

    assign req         = de_sr[0];
    assign column_addr = col_q;
    assign row_addr    = row_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign hsync_sig   = hsync_q;
    assign vsync_sig   = vsync_q;
    assign de          = de_q;
    assign red_sig     = rgb_q[3*RGB_W-1 -: RGB_W];
    assign green_sig   = rgb_q[2*RGB_W-1 -: RGB_W];
    assign blue_sig    = rgb_q[RGB_W-1:0];

endmodule

// File: doc/vga_sync_pipe.md
Name: vga_sync_pipe

Overview:
- Parametrised successor to the fixed 800x600 sync generator: one block that generates hsync/vsync, active-video flag and pixel/line addresses for any timing set.
- Adds a configurable output alignment pipeline. The downstream colour generator sees addresses at cycle t and returns RGB PIPE_DEPTH cycles later; sync, data-enable and RGB then leave the block cycle-aligned.
- Sits between the pixel clock domain root and the VGA pins. The colour/control block hangs off the addr/req side.

Parameters:
- H_SYNC, 120, hsync pulse width in pixel clocks
- H_BACK, 64, horizontal back porch
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch
- V_SYNC, 6, vsync pulse width in lines
- V_BACK, 23, vertical back porch
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- PIPE_DEPTH, 2, cycles from addr/req to rgb_in valid; range 0..15
- RGB_W, 1, bits per colour channel
- AW, 11, address width

Ports:
- clk, input, 1, pixel clock
- rst, input, 1, synchronous active-high reset
- req, output, 1, addresses valid (active region, undelayed)
- column_addr, output, AW, x within active region; 0 when req=0
- row_addr, output, AW, y within active region; 0 when req=0
- frame_start, output, 1, one-cycle pulse at h=0,v=0 (undelayed)
- line_start, output, 1, one-cycle pulse at h=0 of every line (undelayed)
- rgb_in, input, 3*RGB_W, {r,g,b} from colour block, PIPE_DEPTH cycles after req
- hsync_sig, output, 1, delayed hsync
- vsync_sig, output, 1, delayed vsync
- de, output, 1, delayed active flag
- red_sig, output, RGB_W, colour out, blanked when de=0
- green_sig, output, RGB_W, colour out, blanked when de=0
- blue_sig, output, RGB_W, colour out, blanked when de=0

Behaviour:
- Constants: H_TOTAL = sum of the four H params; V_TOTAL likewise.
- Counters: h_cnt 0..H_TOTAL-1 increments every clk.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 from V_TOTAL-1 only when h_cnt also wraps.
- Region order within a line and within a frame: sync, back, active, front.
- Undelayed (stage 0) signals, registered from the counters:
  - hs0 = HS_POL when h_cnt < H_SYNC, else ~HS_POL; vs0 same rule with v_cnt.
  - req asserted when h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) AND v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
  - column_addr = h_cnt-(H_SYNC+H_BACK) and row_addr = v_cnt-(V_SYNC+V_BACK) while req=1; both 0 otherwise.
  - These outputs change on the same edge as req.
- Alignment pipeline: hs0, vs0 and req pass through a PIPE_DEPTH-stage shift register, then one final output register.
  - The output register also samples rgb_in.
  - Total: hsync_sig, vsync_sig and de lag hs0, vs0 and req by PIPE_DEPTH+1 cycles.
  - rgb_in presented PIPE_DEPTH cycles after req is registered alongside them.
  - PIPE_DEPTH=0: rgb_in is sampled in the same cycle as req; outputs lag by 1.
- Blanking: red/green/blue_sig are 0 whenever the registered de is 0, regardless of rgb_in.
- Reset (while rst=1 at a clk edge):
  - h_cnt=0, v_cnt=0.
  - req=0, column_addr=0, row_addr=0, frame_start=0, line_start=0.
  - All pipeline stages cleared to the inactive sync level.
  - hsync_sig=~HS_POL, vsync_sig=~VS_POL, de=0, rgb outputs 0.
- First cycle after rst deasserts:
  - h_cnt=0, v_cnt=0.
  - frame_start=1 and line_start=1 on that cycle (registered from the counter state).
- Reset mid-frame: counters restart at 0,0 with no partial-line completion. The pipeline is flushed, so no stale de or colour appears.
- Widths: counters are AW bits. H_TOTAL and V_TOTAL must be < 2^AW; an elaboration-time check fails otherwise.
- No back-pressure: the timing is free-running and rgb_in is sampled unconditionally.

Test Plan:
- Reset, defaults:
  - Hold rst 5 cycles then release -> hsync_sig=1, vsync_sig=1, de=0 throughout reset.
  - frame_start=1 on the first cycle after release.
  - line_start pulses every 1040 cycles; frame_start pulses every 1040*666 = 692640 cycles.
- Sync widths, defaults:
  - hsync_sig low for exactly 120 cycles per 1040.
  - vsync_sig low for exactly 6*1040 = 6240 cycles per frame.
  - hsync_sig first falls 3 cycles after frame_start (PIPE_DEPTH+1).
- Addressing:
  - req first rises at h=184, v=29 with column_addr=0, row_addr=0.
  - Last active pixel: column_addr=799, row_addr=599.
  - req falls the next cycle and the addresses return to 0.
  - 800*600 = 480000 req cycles per frame.
- Alignment:
  - Model drives rgb_in = {column_addr[0], row_addr[0], 1} delayed 2 cycles.
  - Check every de=1 output pixel matches its own address pattern.
  - Check rgb outputs are 0 when de=0, even with rgb_in=3'b111 forced.
- Mid-frame reset: assert rst for 1 cycle at v=300 -> next cycle h=v=0, frame_start=1; de stays 0 until the pipeline refills.
- Small timing, PIPE_DEPTH=0: H=2/1/4/1, V=1/1/3/1, HS_POL=VS_POL=1 -> line period 8, frame period 48, hsync_sig high 2 cycles per line, de lags req by exactly 1.
